// File: rtl/lcd_touch_i2c_target_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_touch_i2c_target_if
// Bundles the I2C pad lines, the fabric register-load port and the
// host-write notification port of the LCD touch I2C target.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface lcd_touch_i2c_target_if #(
  parameter int AW = 4
);
  logic          scl_in;
  logic          sda_in;
  logic          sda_oe;
  logic          reg_wr_en;
  logic [AW-1:0] reg_wr_addr;
  logic [7:0]    reg_wr_data;
  logic          host_wr_valid;
  logic [AW-1:0] host_wr_addr;
  logic [7:0]    host_wr_data;
  logic          busy;

  // Environment side: pads plus fabric loader
  modport master (
    output scl_in, sda_in, reg_wr_en, reg_wr_addr, reg_wr_data,
    input  sda_oe, host_wr_valid, host_wr_addr, host_wr_data, busy
  );

  // Target side
  modport slave (
    input  scl_in, sda_in, reg_wr_en, reg_wr_addr, reg_wr_data,
    output sda_oe, host_wr_valid, host_wr_addr, host_wr_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/lcd_touch_i2c_target.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_touch_i2c_target
// Oversampled I2C target with a byte-wide register bank: the fabric loads
// touch data, the initiator reads it back or writes it through a pointer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module lcd_touch_i2c_target #(
  parameter logic [6:0] I2C_ADDR   = 7'h38,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  lcd_touch_i2c_target_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA
  logic [1:0] raw;
  logic [1:0] filt;
  assign raw = {bus.sda_in, bus.scl_in};

  for (genvar i = 0; i < 2; i++) begin : g_line
    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] cnt_q, cnt_d;

    // Accept a new line level only after FILTER_LEN consecutive samples of it
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
        if (cnt_q == FW'(FILTER_LEN - 1)) filt_d = sync2_q;
        else                              cnt_d  = cnt_q + 1'b1;
      end
    end

    // Two-stage synchronizer feeding the glitch filter; idle bus level is 1
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw[i];
        sync2_q <= sync1_q;
        filt_q  <= filt_d;
        cnt_q   <= cnt_d;
      end
    end

    assign filt[i] = filt_q;
  end

  logic scl_f, sda_f, scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise =  scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f &  scl_prev_q;
  assign start_ev =  scl_f & scl_prev_q &  sda_prev_q & ~sda_f;
  assign stop_ev  =  scl_f & scl_prev_q & ~sda_prev_q &  sda_f;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          sda_oe_q, sda_oe_d;
  logic          rw_q, rw_d;
  logic          phase_q, phase_d;   // ACK already driven in this ACK slot
  logic          mack_q, mack_d;     // initiator acknowledged last read byte
  logic          hwv_q, hwv_d;
  logic [AW-1:0] hwa_q, hwa_d;
  logic [7:0]    hwd_q, hwd_d;
  logic          host_we;
  logic [7:0]    rx_byte;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic [7:0]    rd_word;

  assign rx_byte = {shift_q[6:0], sda_f};
  assign rd_word = regs_q[ptr_q];

  // Bus protocol sequencing: byte shifting, ACK slots and pointer handling
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    sda_oe_d  = sda_oe_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    mack_d    = mack_q;
    hwv_d     = 1'b0;
    hwa_d     = hwa_q;
    hwd_d     = hwd_q;
    host_we   = 1'b0;
    if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else if (stop_ev) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      phase_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == I2C_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = IDLE;
                end
              end else if (state_q == PTR) begin
                ptr_d   = rx_byte[AW-1:0];
                state_d = PTR_ACK;
              end else begin
                hwv_d   = 1'b1;
                hwa_d   = ptr_q;
                hwd_d   = rx_byte;
                host_we = 1'b1;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d  = 1'b0;
              sda_oe_d = 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                // Snapshot on the edge that starts the byte: tear-free read
                state_d   = RDATA;
                shift_d   = {rd_word[6:0], 1'b0};
                sda_oe_d  = ~rd_word[7];
                bit_cnt_d = 4'd1;
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                if (state_q == WDATA_ACK) ptr_d = ptr_q + 1'b1;
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = '0;
              state_d   = RDATA_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) mack_d = ~sda_f;
          if (scl_fall) begin
            if (mack_q) begin
              state_d   = RDATA;
              shift_d   = {rd_word[6:0], 1'b0};
              sda_oe_d  = ~rd_word[7];
              bit_cnt_d = 4'd1;
            end else begin
              // NACK: stay off the bus until STOP or START; busy holds
              state_d = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register bank update; fabric write is applied last so it wins a collision
  always_comb begin
    regs_d = regs_q;
    if (host_we) regs_d[ptr_q] = rx_byte;
    if (bus.reg_wr_en) regs_d[bus.reg_wr_addr] = bus.reg_wr_data;
  end

  // State and datapath registers; reset releases SDA immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      mack_q     <= 1'b0;
      hwv_q      <= 1'b0;
      hwa_q      <= '0;
      hwd_q      <= '0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      mack_q     <= mack_d;
      hwv_q      <= hwv_d;
      hwa_q      <= hwa_d;
      hwd_q      <= hwd_d;
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      regs_q     <= regs_d;
    end
  end

  assign bus.sda_oe        = sda_oe_q;
  assign bus.busy          = busy_q;
  assign bus.host_wr_valid = hwv_q;
  assign bus.host_wr_addr  = hwa_q;
  assign bus.host_wr_data  = hwd_q;
endmodule
`default_nettype wire
